multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM of the multicycle datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps. Drives every datapath enable and every mux select, including the 2-bit selects of the 4:1 operand and PC-source muxes (alu_src_b, pc_src). Stalls in memory states until the shared instruction/data memory signals mem_ready.

Parameters:
OpWidth, 6, width of the instruction opcode field
StateWidth, 4, width of the state register and of the debug state output

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
opcode  in  OpWidth  instr[31:26], taken from the instruction register
mem_ready  in  1  memory access completes this cycle
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write-register select: 0=rt, 1=rd
mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0=PC, 1=regA
alu_src_b  out  2  ALU B select: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=use funct field
branch  out  1  beq qualifier (PC written when ALU zero)
pc_write  out  1  unconditional PC load
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=unused
illegal_op  out  1  one-cycle pulse on an undefined opcode
state  out  StateWidth  current state (debug/verification)

Behaviour:
- Reset is synchronous, active-high, and overrides everything. With rst high at a rising edge, state becomes FETCH (0). It holds mid-instruction too: no write strobe from the aborted instruction is asserted after the reset edge.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Outputs are decoded combinationally from state, plus mem_ready in the memory states. Unlisted outputs are 0.
- Reset/idle values: every 1-bit output 0; alu_src_b=01; alu_op=00; pc_src=00; state=0.
- FETCH:
  - i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDI_EXEC
  - 000010 -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this cycle only
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: i_or_d=1. Waits while mem_ready=0, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEM_WRITE: i_or_d=1, mem_write=1 while waiting. Goes to FETCH on the cycle mem_ready=1; mem_write stays asserted through that cycle.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- Latency with mem_ready tied high:
  - lw 5 cycles; sw, R-type and addi 4; beq and j 3.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Invariants checked by assertion:
  - At most one of reg_write, mem_write is high in any cycle.
  - pc_write and branch are never high together.
  - ir_write is high only in FETCH.
- opcode is sampled only in DECODE and MEM_ADDR; changes in any other state have no effect.

Test Plan:
- rst=1 for 2 cycles mid-EXECUTE -> state=0; reg_write, mem_write, pc_write all 0; alu_src_b=01 on the cycle after rst falls.
- lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0. alu_src_b sequence 01,11,10,xx,xx. reg_write=1 and mem_to_reg=1 only in cycle 5.
- sw (101011) with mem_ready low for 3 cycles in MEM_WRITE -> stays in state 5 for 4 cycles; mem_write=1 in all 4; then FETCH.
- R-type (000000) then beq (000100) back-to-back with mem_ready=1:
  - R-type: EXECUTE with alu_op=10, alu_src_b=00; ALU_WB with reg_dst=1.
  - beq: BRANCH with alu_op=01, branch=1, pc_src=01; total 4+3 cycles.
- j (000010) -> state 11 with pc_write=1 and pc_src=10, then FETCH. FETCH held 2 cycles with mem_ready=0 -> ir_write=0 and pc_write=0 throughout the hold.
- Opcode 111111 in DECODE -> illegal_op pulses 1 cycle, next state FETCH, no reg_write or mem_write asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback steps. All datapath enables and mux selects are decoded from the
// current state. The memory states additionally look at mem_ready.
module multicycle_control #(
  parameter int OpWidth    = 6,
  parameter int StateWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OpWidth-1:0]    opcode,
  input  logic                  mem_ready,
  output logic                  i_or_d,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  branch,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  illegal_op,
  output logic [StateWidth-1:0] state
);

  typedef enum logic [StateWidth-1:0] {
    S_FETCH     = StateWidth'(0),
    S_DECODE    = StateWidth'(1),
    S_MEM_ADDR  = StateWidth'(2),
    S_MEM_READ  = StateWidth'(3),
    S_MEM_WB    = StateWidth'(4),
    S_MEM_WRITE = StateWidth'(5),
    S_EXECUTE   = StateWidth'(6),
    S_ALU_WB    = StateWidth'(7),
    S_BRANCH    = StateWidth'(8),
    S_ADDI_EXEC = StateWidth'(9),
    S_ADDI_WB   = StateWidth'(10),
    S_JUMP      = StateWidth'(11)
  } state_t;

  localparam logic [OpWidth-1:0] OP_LW   = OpWidth'(6'b100011);
  localparam logic [OpWidth-1:0] OP_SW   = OpWidth'(6'b101011);
  localparam logic [OpWidth-1:0] OP_RTYP = OpWidth'(6'b000000);
  localparam logic [OpWidth-1:0] OP_BEQ  = OpWidth'(6'b000100);
  localparam logic [OpWidth-1:0] OP_ADDI = OpWidth'(6'b001000);
  localparam logic [OpWidth-1:0] OP_J    = OpWidth'(6'b000010);

  state_t state_q;
  state_t state_d;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic: opcode is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    // NOTE: the default assignment first guarantees no latch is inferred for
    // paths that do not assign state_d (including the unused codes 12-15).
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYP)             state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDI_EXEC;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_FETCH;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode: idle values first, then per-state overrides.
  always_comb begin
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b01;
    alu_op     = 2'b00;
    branch     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed here: PC + (imm << 2).
        alu_src_b  = 2'b11;
        illegal_op = !(opcode == OP_LW   || opcode == OP_SW  ||
                       opcode == OP_RTYP || opcode == OP_BEQ ||
                       opcode == OP_ADDI || opcode == OP_J);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ:  i_or_d = 1'b1;
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;

  // Structural invariants of the control word.
  a_one_writer: assert property (@(posedge clk) disable iff (rst)
    !(reg_write && mem_write));
  a_pc_excl: assert property (@(posedge clk) disable iff (rst)
    !(pc_write && branch));
  a_ir_fetch: assert property (@(posedge clk) disable iff (rst)
    ir_write |-> (state_q == S_FETCH));

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process walks a
// reference instruction-path model and queues the expected control word for
// every cycle; an independent monitor pops and compares once per cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, branch, pc_write, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    outs_t ctl;
    logic  care_b;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multicycle_control #(.OpWidth(6), .StateWidth(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .branch(branch), .pc_write(pc_write), .pc_src(pc_src),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input outs_t act, input outs_t exp_v,
                       input logic care_b);
    outs_t a, e;
    a = act;
    e = exp_v;
    if (!care_b) begin
      a.alu_src_b = 2'b00;
      e.alu_src_b = 2'b00;
    end
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, a, e);
  endtask

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000,
                      6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Reference control word for one step of an instruction's walk.
  function automatic outs_t model_outs(input int step, input logic mr,
                                       input logic [5:0] op);
    outs_t o;
    o = '0;
    o.alu_src_b = 2'b01;
    o.state = 4'(step);
    case (step)
      0:  begin o.ir_write = mr; o.pc_write = mr; end
      1:  begin o.alu_src_b = 2'b11; o.illegal_op = !known_op(op); end
      2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      3:  o.i_or_d = 1'b1;
      4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      5:  begin o.i_or_d = 1'b1; o.mem_write = 1'b1; end
      6:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = 2'b10; end
      7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
      8:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = 2'b01;
                o.branch = 1'b1; o.pc_src = 2'b01; end
      9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      10: o.reg_write = 1'b1;
      11: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and, when requested, queue its expectation.
  task automatic drive(input int step, input logic mr, input logic [5:0] op,
                       input logic r, input bit push, input string tag);
    exp_t e;
    rst = r;
    mem_ready = mr;
    opcode = op;
    if (push) begin
      e.ctl = model_outs(step, mr, op);
      e.care_b = step inside {0, 1, 2, 6, 8, 9};
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Walk one instruction; stall counts < 0 mean random 0..2 wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fetch_stall,
                           input int mem_stall, input string tag);
    int path[$];
    int n;
    logic [5:0] drv_op;
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b000100: path = '{0, 1, 8};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
    foreach (path[i]) begin
      drv_op = (path[i] == 1 || path[i] == 2) ? op : 6'($urandom);
      if (path[i] inside {0, 3, 5}) begin
        n = (path[i] == 0) ? fetch_stall : mem_stall;
        if (n < 0) n = $urandom_range(0, 2);
        repeat (n) drive(path[i], 1'b0, drv_op, 1'b0, 1'b1, tag);
        drive(path[i], 1'b1, drv_op, 1'b0, 1'b1, tag);
      end else begin
        drive(path[i], 1'($urandom), drv_op, 1'b0, 1'b1, tag);
      end
    end
  endtask

  // Monitor: one control word presented per cycle, compared just before the edge.
  initial begin
    outs_t act;
    exp_t  e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, branch, pc_write, pc_src,
                illegal_op, state};
        check(e.tag, act, e.ctl, e.care_b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [5:0] ops[7];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
            6'b111111};
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    @(negedge clk);
    drive(0, 1'b0, 6'h00, 1'b1, 1'b0, "reset");
    drive(0, 1'b0, 6'h00, 1'b1, 1'b1, "reset_state");
    drive(0, 1'b0, 6'h00, 1'b0, 1'b1, "reset_release");

    // R-type aborted by a two-cycle reset in EXECUTE.
    drive(0, 1'b1, 6'h00, 1'b0, 1'b1, "abort_fetch");
    drive(1, 1'b0, 6'h00, 1'b0, 1'b1, "abort_decode");
    drive(6, 1'b0, 6'h00, 1'b1, 1'b1, "abort_execute");
    drive(0, 1'b0, 6'h00, 1'b1, 1'b1, "abort_in_reset");
    drive(0, 1'b0, 6'h00, 1'b0, 1'b1, "after_reset_fetch");

    run_instr(6'b100011, 0, 0, "lw");
    run_instr(6'b101011, 0, 3, "sw_stall");
    run_instr(6'b000000, 0, 0, "rtype");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 2, 0, "j_fetch_hold");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b100011, 1, 2, "lw_stall");

    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, -1, -1, "random");
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
